dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer for the DDS phase-accumulator/sine-LUT DAC datapath. Drives the DDS tuning word `PhaseIn` and the `Load` strobe. It steps the tuning word from a start value to a stop value in fixed increments, holds each point for a programmable dwell time, and supports single-shot and continuous (repeating) sweeps. It sits between the host/config registers and the DDS core.

Parameters:
- PW, 16, tuning-word width (matches DDS `PhaseIn`).
- DW, 16, dwell-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  synchronous stop from any state.
- cont  input  1  1 = continuous sweep; 0 = single-shot. Captured at start.
- f_start  input  PW  first tuning word. Captured at start.
- f_stop  input  PW  final tuning word. Captured at start.
- f_step  input  PW  increment magnitude. Captured at start.
- dwell  input  DW  cycles per point after the load cycle. Captured at start; 0 is treated as 1.
- phase_inc  output  PW  tuning word to DDS `PhaseIn`.
- load  output  1  one-cycle strobe to DDS `Load`.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle end-of-sweep pulse.

Behaviour:
- Reset (asynchronous, any time including mid-sweep):
  - state = IDLE.
  - phase_inc = 0, load = 0, busy = 0, done = 0, dwell counter = 0.
- States: IDLE, LOAD, DWELL, DONE. All outputs are decoded from registered state or are registers; there are no combinational input-to-output paths.
- IDLE:
  - If start=1 and abort=0 at an edge: capture cont, f_start, f_stop, f_step, and dwell (0 becomes 1).
  - At the same edge, set cur = f_start and dir = down if f_stop < f_start, else up.
  - Next state is LOAD.
- LOAD (exactly 1 cycle):
  - load = 1, busy = 1, phase_inc = cur.
  - Dwell counter is loaded with dwell−1.
  - Next state is DWELL.
- DWELL (exactly `dwell` cycles):
  - load = 0, busy = 1, phase_inc holds.
  - The counter decrements each cycle.
  - At count 0: if cur == f_stop, go to DONE. Otherwise set cur = next and go to LOAD.
  - Each sweep point therefore occupies 1 + dwell cycles.
- next (computed at PW+1 bits):
  - Up: sum = cur + f_step. If sum ≥ f_stop or carry out, next = f_stop; else next = sum.
  - Down: diff = cur − f_step. If diff ≤ f_stop or borrow, next = f_stop; else next = diff.
  - The final point is always exactly f_stop (clamped, never overshot).
- f_step == 0: treated as single-point. After the first dwell, go to DONE regardless of cur.
- f_start == f_stop: single point, then DONE.
- DONE (1 cycle):
  - done = 1, load = 0.
  - cont = 0: busy = 0, next state IDLE.
  - cont = 1: busy stays 1, cur = f_start, next state LOAD. The sweep repeats until abort.
- phase_inc retains its last value in IDLE and after done/abort, so the DDS keeps running at the final frequency.
- start while not in IDLE: ignored. Input config changes while busy: ignored (the captured copy is used).
- abort=1 at any edge in LOAD, DWELL, or DONE:
  - Next state is IDLE; busy = 0 and load = 0 from the next cycle.
  - No done pulse is produced; phase_inc holds.
  - abort has priority over start and over all transitions. abort in IDLE has no effect.

Test Plan:
- Up sweep: f_start=100, f_stop=130, f_step=10, dwell=3, cont=0, pulse start → load pulses with phase_inc = 100, 110, 120, 130, spaced 4 cycles apart; done = 1 for one cycle, 4 cycles after the 130 load; busy falls with done; phase_inc stays 130.
- Clamp/down: f_stop=125 (up) → loads 100, 110, 120, 125. Then a down sweep with f_start=500, f_stop=480, f_step=7 → loads 500, 493, 486, 480. Also f_start=0xFFF0, f_stop=0xFFFF, f_step=0x20 → loads 0xFFF0, 0xFFFF (carry clamped).
- Degenerate: f_step=0 or f_start==f_stop with dwell=0 → one load, dwell of 1 cycle, done 2 cycles after load; busy high for exactly 2 cycles.
- Abort: abort during the second DWELL of the up sweep → busy = 0 and load = 0 next cycle, no done, phase_inc = 110. A simultaneous start + abort in IDLE → stays IDLE.
- Continuous: cont=1, 100→120 step 10, dwell=1 → load sequence 100, 110, 120, done, 100, 110, …; busy stays 1 through done; abort ends it.
- Reset mid-sweep: assert rst asynchronously between clock edges during DWELL → all outputs 0 immediately; a new start after release sweeps from f_start. A start issued while busy is ignored (checked against the load sequence).

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS core: steps the tuning word from f_start
// to f_stop, holds each point for a dwell time, single-shot or continuous.
module dds_sweep_ctrl #(
  parameter int PW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [PW-1:0] phase_inc,
  output logic          load,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] start_q, start_d;
  logic [PW-1:0] stop_q, stop_d;
  logic [PW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          cont_q, cont_d;
  logic          down_q, down_d;

  logic [PW:0]   sum;
  logic [PW:0]   diff;
  logic [PW-1:0] next_pt;

  // Next point, computed one bit wider so carry/borrow clamp to f_stop.
  always_comb begin
    sum  = {1'b0, cur_q} + {1'b0, step_q};
    diff = {1'b0, cur_q} - {1'b0, step_q};
    if (down_q) begin
      next_pt = (diff[PW] || (diff[PW-1:0] <= stop_q)) ? stop_q : diff[PW-1:0];
    end else begin
      next_pt = (sum[PW] || (sum[PW-1:0] >= stop_q)) ? stop_q : sum[PW-1:0];
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    down_d  = down_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cont_d  = cont;
          start_d = f_start;
          stop_d  = f_stop;
          step_d  = f_step;
          dwell_d = (dwell == '0) ? DW'(1) : dwell;
          cur_d   = f_start;
          down_d  = (f_stop < f_start);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = dwell_q - DW'(1);
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if ((cur_q == stop_q) || (step_q == '0)) begin
          state_d = S_DONE;
        end else begin
          cur_d   = next_pt;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (cont_q) begin
          cur_d   = start_q;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Abort overrides every transition; the tuning word is left where it was.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cur_d   = cur_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      down_q  <= down_d;
    end
  end

  assign phase_inc = cur_q;
  assign load      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_DWELL) ||
                     ((state_q == S_DONE) && cont_q);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a scoreboard of expected load values
// plus per-scenario timing, busy/done and hold checks.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        cont;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic [15:0] phase_inc;
  logic        load;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  typedef struct packed {
    logic [15:0] fs;
    logic [15:0] fe;
    logic [15:0] st;
    logic [15:0] dw;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] p3;
    logic [15:0] fin;
    logic [2:0]  n;
  } case_t;

  dds_sweep_ctrl #(.PW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phase_inc (phase_inc),
    .load      (load),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every load strobe must match the next expected tuning word.
  always @(negedge clk) begin
    if (!rst && load) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_load: unexpected load with phase_inc=%0d, nothing expected", phase_inc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (phase_inc !== sb_exp) begin
          n_err++;
          $display("FAIL sb_load: phase_inc=%0d expected %0d", phase_inc, sb_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Launch a sweep; returns at the negedge where the first load is visible.
  // Inputs are scrambled afterwards since the DUT must use its captured copy.
  task automatic start_sweep(input logic [15:0] fs, input logic [15:0] fe,
                             input logic [15:0] st, input logic [15:0] dw,
                             input logic c);
    @(negedge clk);
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    cont    = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    f_start = 16'($urandom);
    f_stop  = 16'($urandom);
    f_step  = 16'($urandom);
    dwell   = 16'($urandom_range(0, 7));
    cont    = 1'($urandom_range(0, 1));
  endtask

  // Observer only: walks the sweep until done and reports what it saw.
  task automatic run_to_done(input int dw_eff, input int limit, input bit poke,
                             output int n_loads, output int gap, output int busy_cyc,
                             output logic done_busy, output int bad_gap, output bit timeout);
    int  last = -1;
    bit  found = 1'b0;
    n_loads   = 0;
    gap       = -1;
    busy_cyc  = 0;
    done_busy = 1'bx;
    bad_gap   = 0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (load) begin
        if (last >= 0 && (cyc - last) != (1 + dw_eff)) bad_gap++;
        last = cyc;
        n_loads++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        gap       = cyc - last;
        done_busy = busy;
        found     = 1'b1;
        break;
      end
      if (poke && cyc == 2) begin
        start   = 1'b1;
        f_start = 16'd999;
        f_stop  = 16'd1000;
        f_step  = 16'd1;
        dwell   = 16'd0;
        cont    = 1'b1;
      end
      if (poke && cyc == 3) start = 1'b0;
    end
    timeout = !found;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    #3;
    n_cmp++; if (phase_inc !== 16'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", phase_inc); end
    n_cmp++; if (load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b expected 0", load); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_sweep();
    int nl, gap, bc, bad; logic db; bit to;
    exp_q.push_back(16'd100); exp_q.push_back(16'd110);
    exp_q.push_back(16'd120); exp_q.push_back(16'd130);
    start_sweep(16'd100, 16'd130, 16'd10, 16'd3, 1'b0);
    run_to_done(3, 100, 1'b0, nl, gap, bc, db, bad, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL up_timeout: no done seen within 100 cycles"); end
    n_cmp++; if (nl != 4) begin n_err++; $display("FAIL up_nloads: got %0d expected 4", nl); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL up_spacing: %0d loads not 4 cycles apart", bad); end
    n_cmp++; if (gap != 4) begin n_err++; $display("FAIL up_done_gap: got %0d expected 4", gap); end
    n_cmp++; if (db !== 1'b0) begin n_err++; $display("FAIL up_busy_at_done: got %b expected 0", db); end
    n_cmp++; if (bc != 16) begin n_err++; $display("FAIL up_busy_cycles: got %0d expected 16", bc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL up_sb_left: %0d loads missing", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL up_done_width: got %b expected 0", done); end
    n_cmp++; if (phase_inc !== 16'd130) begin n_err++; $display("FAIL up_hold: got %0d expected 130", phase_inc); end
  endtask

  // Clamping up, down sweep, carry clamp and the single-point cases.
  task automatic test_point_sequences();
    case_t cs[5];
    int nl, gap, bc, bad, dwe; logic db; bit to;
    cs[0] = '{fs:16'd100, fe:16'd125, st:16'd10, dw:16'd3, p0:16'd100, p1:16'd110,
              p2:16'd120, p3:16'd125, fin:16'd125, n:3'd4};
    cs[1] = '{fs:16'd500, fe:16'd480, st:16'd7, dw:16'd2, p0:16'd500, p1:16'd493,
              p2:16'd486, p3:16'd480, fin:16'd480, n:3'd4};
    cs[2] = '{fs:16'hFFF0, fe:16'hFFFF, st:16'h0020, dw:16'd1, p0:16'hFFF0, p1:16'hFFFF,
              p2:16'd0, p3:16'd0, fin:16'hFFFF, n:3'd2};
    cs[3] = '{fs:16'd200, fe:16'd300, st:16'd0, dw:16'd0, p0:16'd200, p1:16'd0,
              p2:16'd0, p3:16'd0, fin:16'd200, n:3'd1};
    cs[4] = '{fs:16'd77, fe:16'd77, st:16'd5, dw:16'd0, p0:16'd77, p1:16'd0,
              p2:16'd0, p3:16'd0, fin:16'd77, n:3'd1};
    for (int i = 0; i < 5; i++) begin
      dwe = (cs[i].dw == 16'd0) ? 1 : int'(cs[i].dw);
      exp_q.push_back(cs[i].p0);
      if (cs[i].n > 3'd1) exp_q.push_back(cs[i].p1);
      if (cs[i].n > 3'd2) exp_q.push_back(cs[i].p2);
      if (cs[i].n > 3'd3) exp_q.push_back(cs[i].p3);
      start_sweep(cs[i].fs, cs[i].fe, cs[i].st, cs[i].dw, 1'b0);
      run_to_done(dwe, 100, 1'b0, nl, gap, bc, db, bad, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL seq%0d_timeout: no done seen", i); end
      n_cmp++; if (nl != int'(cs[i].n)) begin n_err++; $display("FAIL seq%0d_nloads: got %0d expected %0d", i, nl, cs[i].n); end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL seq%0d_spacing: %0d bad load gaps", i, bad); end
      n_cmp++; if (gap != 1 + dwe) begin n_err++; $display("FAIL seq%0d_done_gap: got %0d expected %0d", i, gap, 1 + dwe); end
      n_cmp++; if (bc != int'(cs[i].n) * (1 + dwe)) begin n_err++; $display("FAIL seq%0d_busy_cycles: got %0d expected %0d", i, bc, int'(cs[i].n) * (1 + dwe)); end
      n_cmp++; if (db !== 1'b0) begin n_err++; $display("FAIL seq%0d_busy_at_done: got %b expected 0", i, db); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq%0d_sb_left: %0d loads missing", i, exp_q.size()); end
      exp_q.delete();
      @(negedge clk);
      n_cmp++; if (phase_inc !== cs[i].fin) begin n_err++; $display("FAIL seq%0d_hold: got %0h expected %0h", i, phase_inc, cs[i].fin); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL seq%0d_idle: busy=%b done=%b expected 0 0", i, busy, done); end
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    exp_q.push_back(16'd100); exp_q.push_back(16'd110);
    start_sweep(16'd100, 16'd130, 16'd10, 16'd3, 1'b0);
    // Cycle 0 is the first load, cycle 4 the second, cycle 5 its first dwell.
    for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
    n_cmp++; if (load !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL abort_pre: load=%b busy=%b expected 0 1", load, busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (load !== 1'b0) begin n_err++; $display("FAIL abort_load: got %b expected 0", load); end
    n_cmp++; if (phase_inc !== 16'd110) begin n_err++; $display("FAIL abort_hold: got %0d expected 110", phase_inc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_sb_left: %0d loads missing", exp_q.size()); end
    exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || load || busy) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_quiet: %0d active cycles after abort, expected 0", seen); end
    // Start together with abort in IDLE must be ignored.
    f_start = 16'd5; f_stop = 16'd9; f_step = 16'd1; dwell = 16'd1; cont = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (load || busy || done) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL start_abort_idle: %0d active cycles, expected 0", seen); end
    n_cmp++; if (phase_inc !== 16'd110) begin n_err++; $display("FAIL start_abort_hold: got %0d expected 110", phase_inc); end
  endtask

  task automatic test_continuous();
    int nl, gap, bc, bad, nl2; logic db; bit to;
    nl2 = 0;
    exp_q.push_back(16'd100); exp_q.push_back(16'd110); exp_q.push_back(16'd120);
    exp_q.push_back(16'd100); exp_q.push_back(16'd110);
    start_sweep(16'd100, 16'd120, 16'd10, 16'd1, 1'b1);
    run_to_done(1, 100, 1'b0, nl, gap, bc, db, bad, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL cont_timeout: no done seen"); end
    n_cmp++; if (nl != 3) begin n_err++; $display("FAIL cont_nloads: got %0d expected 3", nl); end
    n_cmp++; if (gap != 2) begin n_err++; $display("FAIL cont_done_gap: got %0d expected 2", gap); end
    n_cmp++; if (db !== 1'b1) begin n_err++; $display("FAIL cont_busy_at_done: got %b expected 1", db); end
    n_cmp++; if (bc != 7) begin n_err++; $display("FAIL cont_busy_cycles: got %0d expected 7", bc); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (load) nl2++;
      if (k == 1) begin
        n_cmp++; if (done !== 1'b0 || load !== 1'b1) begin n_err++; $display("FAIL cont_restart: done=%b load=%b expected 0 1", done, load); end
      end
      if (k == 4) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (nl2 != 2) begin n_err++; $display("FAIL cont_second_pass: got %0d loads expected 2", nl2); end
    n_cmp++; if (busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL cont_abort: busy=%b load=%b done=%b expected 0 0 0", busy, load, done); end
    n_cmp++; if (phase_inc !== 16'd110) begin n_err++; $display("FAIL cont_hold: got %0d expected 110", phase_inc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL cont_sb_left: %0d loads missing", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_and_busy_start();
    int nl, gap, bc, bad; logic db; bit to;
    exp_q.push_back(16'd100); exp_q.push_back(16'd110);
    exp_q.push_back(16'd120); exp_q.push_back(16'd130);
    start_sweep(16'd100, 16'd130, 16'd10, 16'd3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (phase_inc !== 16'd0) begin n_err++; $display("FAIL rstmid_phase: got %0d expected 0", phase_inc); end
    n_cmp++; if (busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: busy=%b load=%b done=%b expected 0 0 0", busy, load, done); end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'd100); exp_q.push_back(16'd110);
    exp_q.push_back(16'd120); exp_q.push_back(16'd130);
    start_sweep(16'd100, 16'd130, 16'd10, 16'd3, 1'b0);
    run_to_done(3, 100, 1'b1, nl, gap, bc, db, bad, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL restart_timeout: no done seen"); end
    n_cmp++; if (nl != 4) begin n_err++; $display("FAIL restart_nloads: got %0d expected 4", nl); end
    n_cmp++; if (bad != 0 || gap != 4) begin n_err++; $display("FAIL restart_timing: bad=%0d gap=%0d expected 0 4", bad, gap); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL restart_sb_left: %0d loads missing", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || phase_inc !== 16'd130) begin n_err++; $display("FAIL restart_end: busy=%b phase_inc=%0d expected 0 130", busy, phase_inc); end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_point_sequences();
    test_abort();
    test_continuous();
    test_reset_mid_and_busy_start();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
